// File: rtl/efi_pkg.sv
// Shared types and defaults for the EFI crank/cam decoding blocks.
package efi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEARN    = 2'd1,
        SEEK_GAP = 2'd2,
        SYNCED   = 2'd3
    } crank_state_t;

    localparam int TEETH_DEF    = 36;
    localparam int MISSING_DEF  = 1;
    localparam int PERIOD_W_DEF = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a registered rising-edge strobe; strobe appears
// three clk cycles after the pin rises.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic last_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            last_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            last_q <= sync_q;
            rise_q <= sync_q & ~last_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/crank_decoder.sv
// Missing-tooth crank wheel decoder: measures tooth periods, locks on the gap.
// Optional build macro CRANK_NOISE_FILTER_EN discards edges shorter than prev/4.
module crank_decoder
    import efi_pkg::*;
#(
    parameter int TEETH       = TEETH_DEF,
    parameter int MISSING     = MISSING_DEF,
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int STALL_TICKS = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vrin,
    output logic                       synced,
    output logic [idx_w(TEETH)-1:0]    tooth_idx,
    output logic [PERIOD_W-1:0]        tooth_period,
    output logic                       tooth_strobe,
    output logic                       rev_pulse,
    output logic                       sync_err
);

    localparam int IW = idx_w(TEETH);
    localparam int GW = PERIOD_W + 3;
    localparam logic [IW-1:0]       LAST_IDX  = IW'(TEETH - MISSING - 1);
    localparam logic [PERIOD_W-1:0] STALL_CNT = PERIOD_W'(STALL_TICKS);
    localparam logic [GW-1:0]       GAP_MUL   = GW'(2 * MISSING + 1);

    crank_state_t        state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] prev_q, prev_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                synced_q, synced_d;
    logic                strobe_q, strobe_d;
    logic                rev_q, rev_d;
    logic                err_q, err_d;

    logic edge_raw;
    logic edge_ok;
    logic noise;
    logic is_gap;
    logic at_last;
    logic stall;

    edge_sync u_vr_sync (
        .clk    (clk),
        .rst    (rst),
        .din_i  (vrin),
        .rise_o (edge_raw)
    );

    // cnt_q holds the period of the edge being evaluated; 3 spare bits keep prev*5 exact
    assign is_gap  = ({2'b00, cnt_q, 1'b0} >= (GW'(prev_q) * GAP_MUL));
    assign at_last = (idx_q == LAST_IDX);
    assign stall   = (cnt_q >= STALL_CNT);

`ifdef CRANK_NOISE_FILTER_EN
    assign noise = ((state_q == SEEK_GAP) || (state_q == SYNCED)) &&
                   ({cnt_q, 2'b00} < {2'b00, prev_q});
`else
    assign noise = 1'b0;
`endif

    assign edge_ok = edge_raw & ~noise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= '0;
            period_q <= '0;
            idx_q    <= '0;
            synced_q <= 1'b0;
            strobe_q <= 1'b0;
            rev_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            period_q <= period_d;
            idx_q    <= idx_d;
            synced_q <= synced_d;
            strobe_q <= strobe_d;
            rev_q    <= rev_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (edge_ok) begin
            case (state_q)
                IDLE:     state_d = LEARN;
                LEARN:    state_d = SEEK_GAP;
                SEEK_GAP: state_d = is_gap ? SYNCED : SEEK_GAP;
                SYNCED:   state_d = (is_gap == at_last) ? SYNCED : SEEK_GAP;
                default:  state_d = IDLE;
            endcase
        end else if (stall) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        prev_d   = prev_q;
        period_d = period_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        rev_d    = 1'b0;
        err_d    = 1'b0;
        if (edge_ok) begin
            cnt_d = PERIOD_W'(1);
            case (state_q)
                LEARN: begin
                    strobe_d = 1'b1;
                    prev_d   = cnt_q;
                    period_d = cnt_q;
                end
                SEEK_GAP: begin
                    strobe_d = 1'b1;
                    if (is_gap) begin
                        idx_d = '0;
                    end else begin
                        prev_d   = cnt_q;
                        period_d = cnt_q;
                    end
                end
                SYNCED: begin
                    strobe_d = 1'b1;
                    if (at_last && is_gap) begin
                        idx_d = '0;
                        rev_d = 1'b1;
                    end else if (!at_last && !is_gap) begin
                        idx_d    = idx_q + 1'b1;
                        prev_d   = cnt_q;
                        period_d = cnt_q;
                    end else begin
                        // Gap where a tooth belongs, or tooth where the gap belongs
                        err_d  = 1'b1;
                        idx_d  = '0;
                        prev_d = cnt_q;
                        if (!is_gap) begin
                            period_d = cnt_q;
                        end
                    end
                end
                default: ;
            endcase
        end else if (stall) begin
            idx_d = '0;
        end
        synced_d = (state_d == SYNCED);
    end

    assign synced       = synced_q;
    assign tooth_idx    = idx_q;
    assign tooth_period = period_q;
    assign tooth_strobe = strobe_q;
    assign rev_pulse    = rev_q;
    assign sync_err     = err_q;

endmodule

// File: doc/crank_decoder.md
Name: crank_decoder

Overview:
- Receive-side decoder for the missing-tooth crank trigger train.
- Consumes the squared VR signal, which comes either from the trigger conditioner or from the on-board pattern generator.
- Measures the period of each tooth and finds the missing-tooth gap.
- Produces sync status, tooth index, last tooth period and a once-per-revolution pulse for the scheduling logic in efi_main.

Parameters:
- TEETH, 36, physical tooth positions per revolution, missing positions included
- MISSING, 1, consecutive missing teeth forming the gap (1 or 2)
- PERIOD_W, 16, width of the period counter and the tooth_period output
- STALL_TICKS, 50000, clk cycles without an edge before the engine is declared stopped (25 ms at 2 MHz)

Ports:
- clk  in  1  decoder clock, clk_efi domain (2 MHz)
- rst  in  1  reset, synchronous, active-high
- vrin  in  1  asynchronous squared crank signal; a rising edge is a tooth
- synced  out  1  high while the decoder is locked to the wheel
- tooth_idx  out  $clog2(TEETH)  index of the current tooth; 0 is the first tooth after the gap
- tooth_period  out  PERIOD_W  clk cycles between the last two non-gap edges
- tooth_strobe  out  1  one-cycle pulse on every accepted edge
- rev_pulse  out  1  one-cycle pulse on the gap edge while synced
- sync_err  out  1  one-cycle pulse when an unexpected gap or a missing gap drops sync

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0, period counter 0.
- Synchroniser: two flops followed by a rising-edge detect. The internal edge strobe fires 3 clk cycles after the pin rises. A pin held high across reset yields one edge after reset release; that edge is harmless in IDLE.
- Period counter:
  - Increments every cycle and saturates at 2^PERIOD_W-1.
  - On an edge, cur = counter value and the counter loads 1.
  - Edges spaced N cycles apart therefore give cur = N.
- Gap test: cur*2 >= prev*(2*MISSING+1), where prev is the last non-gap period. For MISSING=1 this is a ratio of at least 1.5. Evaluate at PERIOD_W+3 bits; no overflow is allowed.
- States:
  - IDLE: the first edge goes to LEARN.
  - LEARN: the next edge sets prev=cur and goes to SEEK_GAP.
  - SEEK_GAP:
    - Non-gap edge: prev=cur.
    - Gap edge: go to SYNCED, tooth_idx=0, synced=1, rev_pulse not asserted.
  - SYNCED:
    - tooth_idx increments on each edge.
    - When tooth_idx == TEETH-MISSING-1, the next edge must pass the gap test. If it does: tooth_idx=0, rev_pulse=1.
    - An edge failing the gap test where a gap is expected, or passing it elsewhere: sync_err=1, synced=0, go to SEEK_GAP, prev=cur.
- tooth_period and prev update on non-gap edges only. Gap edges never update them.
- tooth_strobe fires on every edge accepted in LEARN, SEEK_GAP or SYNCED.
- Stall: counter >= STALL_TICKS with no edge → IDLE, synced=0, tooth_idx=0, tooth_period held. No sync_err is raised on stall.
- Edge and stall threshold in the same cycle: the edge wins.
- All outputs are registered. Pulses last exactly one cycle, in the cycle after the internal edge strobe.
- rst asserted mid-revolution: return to the reset state on the next clk edge regardless of state.

Optional Feature:
- Macro: CRANK_NOISE_FILTER_EN.
- Defined: an edge with cur*4 < prev is discarded as noise.
  - The counter is not reloaded; no strobe, no index change.
  - Active only in SEEK_GAP and SYNCED.
- Undefined: every synchronised rising edge is processed.

Decomposition:
- efi_pkg holds:
  - the state enum (IDLE, LEARN, SEEK_GAP, SYNCED);
  - the default constants for TEETH, MISSING and PERIOD_W;
  - the tooth-index width function.
- One sub-module, edge_sync: 2-flop synchroniser plus rising-edge strobe, reset to 0, reusable for the cam input.

Test Plan:
- Lock: after reset, drive 3 teeth at 1000 cycles, then a 2000-cycle gap → synced=1 and tooth_idx=0 on the gap edge, tooth_period=1000, no rev_pulse.
- Steady run: 3 revolutions of 35×1000 teeth plus a 2000 gap → tooth_idx counts 0..34, rev_pulse once per gap, sync_err never asserted.
- Extra gap: while synced at tooth_idx=10, insert a 2000-cycle period → sync_err pulse, synced=0. Resync on the next true gap.
- Missing gap: while synced, replace the gap with a 1000-cycle tooth → sync_err on that edge, state SEEK_GAP.
- Stall: stop edges for 50000 cycles → synced=0, tooth_idx=0 at exactly cycle 50000. The next 3 teeth plus gap relock.
- Noise (macro defined): while synced at 1000-cycle spacing, inject a glitch edge 200 cycles after a tooth → ignored, tooth_idx unchanged, next tooth_period=1000.
